// File: rtl/quad_step_if.sv
// Command channel of the quadrature step generator: valid/ready handshake,
// command fields and the abort strobe.
interface quad_step_if #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [DIV_W-1:0] cmd_period;
    logic             abort;

    modport master (
        output cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
        output cmd_ready
    );
endinterface

// File: rtl/quad_step_gen.sv
// Quadrature waveform generator: emits a/b Gray transitions at a programmable
// rate for each accepted step command and tracks a signed position count.
module quad_step_gen #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16,
    parameter int POS_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    quad_step_if.slave       cmd,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] position
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r;
    logic             dir_r;
    logic [CNT_W-1:0] steps_left_r;
    logic [DIV_W-1:0] period_r;
    logic [DIV_W-1:0] timer_r;
    logic             a_r;
    logic             b_r;
    logic             busy_r;
    logic             done_r;
    logic             ready_r;
    logic [POS_W-1:0] pos_r;

    logic [DIV_W-1:0] period_eff_s;
    logic [1:0]       next_ab_s;

    // One Gray step of {a,b}: CW walks 00,10,11,01; CCW walks the reverse.
    function automatic logic [1:0] gray_next(input logic [1:0] ab, input logic ccw);
        logic [1:0] nxt;
        if (ccw) begin
            nxt = {ab[0], ~ab[1]};
        end else begin
            nxt = {~ab[0], ab[1]};
        end
        return nxt;
    endfunction

    // Effective period clamp and the next quadrature phase in the latched direction.
    always_comb begin
        period_eff_s = cmd.cmd_period;
        if (cmd.cmd_period == {DIV_W{1'b0}}) begin
            period_eff_s = DIV_W'(1);
        end else begin
            period_eff_s = cmd.cmd_period;
        end
        next_ab_s = gray_next({a_r, b_r}, dir_r);
    end

    // Command FSM, period timer, step counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            dir_r        <= 1'b0;
            steps_left_r <= {CNT_W{1'b0}};
            period_r     <= {DIV_W{1'b0}};
            timer_r      <= {DIV_W{1'b0}};
            a_r          <= 1'b0;
            b_r          <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            ready_r      <= 1'b1;
            pos_r        <= {POS_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // Abort has no meaning here; a simultaneous command still lands.
                    if (cmd.cmd_valid && ready_r) begin
                        dir_r    <= cmd.cmd_dir;
                        period_r <= period_eff_s;
                        if (cmd.cmd_steps == {CNT_W{1'b0}}) begin
                            done_r <= 1'b1;
                        end else begin
                            state_r      <= RUN;
                            busy_r       <= 1'b1;
                            ready_r      <= 1'b0;
                            timer_r      <= period_eff_s - DIV_W'(1);
                            steps_left_r <= cmd.cmd_steps;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (cmd.abort) begin
                        // Abort beats a due transition: outputs and position freeze.
                        state_r      <= IDLE;
                        busy_r       <= 1'b0;
                        ready_r      <= 1'b1;
                        timer_r      <= {DIV_W{1'b0}};
                        steps_left_r <= {CNT_W{1'b0}};
                    end else if (timer_r == {DIV_W{1'b0}}) begin
                        {a_r, b_r} <= next_ab_s;
                        pos_r      <= dir_r ? (pos_r - POS_W'(1)) : (pos_r + POS_W'(1));
                        timer_r    <= period_r - DIV_W'(1);
                        if (steps_left_r == CNT_W'(1)) begin
                            state_r      <= IDLE;
                            busy_r       <= 1'b0;
                            ready_r      <= 1'b1;
                            done_r       <= 1'b1;
                            steps_left_r <= {CNT_W{1'b0}};
                        end else begin
                            steps_left_r <= steps_left_r - CNT_W'(1);
                        end
                    end else begin
                        timer_r <= timer_r - DIV_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign a             = a_r;
    assign b             = b_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign position      = pos_r;
    assign cmd.cmd_ready = ready_r;

endmodule

// File: tb/tb_quad_step_gen.sv
// Self-checking bench for quad_step_gen: hand-computed command table, abort and
// back-to-back sequences, and random commands against a timeline model plus a decoder.
module tb_quad_step_gen;
    logic        clk;
    logic        rst_n;
    logic        a;
    logic        b;
    logic        busy;
    logic        done;
    logic [15:0] position;

    quad_step_if #(.CNT_W(16), .DIV_W(16)) bus ();

    quad_step_gen #(.CNT_W(16), .DIV_W(16), .POS_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (bus),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .position (position)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the command is a timeline starting at accept edge m_k.
    int          cyc     = 0;
    logic        m_busy  = 1'b0;
    logic        m_done  = 1'b0;
    logic        m_dir   = 1'b0;
    int          m_k     = 0;
    int          m_n     = 0;
    int          m_p     = 1;
    int          m_phase = 0;
    logic [15:0] m_pos   = 16'h0000;
    logic [1:0]  ab_of [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    // Independent edge-counting decoder on the a/b pair.
    logic [1:0]  prev_ab = 2'b00;
    logic [15:0] dec_pos = 16'h0000;
    int          illegal = 0;

    typedef struct {
        logic        dir;
        logic [15:0] steps;
        logic [15:0] period;
        logic [1:0]  ab;
        logic [15:0] pos;
        int          lat;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int gidx(input logic [1:0] ab);
        int r;
        case (ab)
            2'b00:   r = 0;
            2'b10:   r = 1;
            2'b11:   r = 2;
            2'b01:   r = 3;
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic model_edge();
        int d;
        m_done = 1'b0;
        if (m_busy) begin
            if (bus.abort) begin
                m_busy = 1'b0;
            end else begin
                d = cyc - m_k;
                if (d % m_p == 0) begin
                    m_phase = (m_phase + (m_dir ? 3 : 1)) % 4;
                    m_pos   = m_pos + (m_dir ? 16'hFFFF : 16'h0001);
                    if (d / m_p == m_n) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
        end else if (bus.cmd_valid) begin
            m_dir = bus.cmd_dir;
            m_p   = (bus.cmd_period == 16'd0) ? 1 : int'(bus.cmd_period);
            if (bus.cmd_steps == 16'd0) begin
                m_done = 1'b1;
            end else begin
                m_busy = 1'b1;
                m_k    = cyc;
                m_n    = int'(bus.cmd_steps);
            end
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_phase = 0;
        m_pos   = 16'h0000;
        prev_ab = 2'b00;
        dec_pos = 16'h0000;
    endtask

    task automatic cyc_step();
        int diff;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        chk("cycle", 32'({a, b, busy, done, bus.cmd_ready, position}),
            32'({ab_of[m_phase], m_busy, m_done, ~m_busy, m_pos}));
        diff = (gidx({a, b}) - gidx(prev_ab) + 4) % 4;
        if (diff == 1) dec_pos = dec_pos + 16'h0001;
        else if (diff == 3) dec_pos = dec_pos - 16'h0001;
        else if (diff == 2) illegal++;
        prev_ab = {a, b};
    endtask

    task automatic run_cmd(input logic dir, input logic [15:0] steps, input logic [15:0] period,
                           output int lat);
        bus.cmd_dir    = dir;
        bus.cmd_steps  = steps;
        bus.cmd_period = period;
        bus.cmd_valid  = 1'b1;
        cyc_step();
        bus.cmd_valid  = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 1000) begin
            cyc_step();
            lat++;
        end
        if (lat >= 1000) chk("done_timeout", 32'(done), 32'd1);
        cyc_step();
    endtask

    int lat;
    int guard;
    logic [15:0] pos0;

    initial begin
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_dir    = 1'b0;
        bus.cmd_steps  = 16'd0;
        bus.cmd_period = 16'd0;
        bus.abort      = 1'b0;

        tbl[0] = '{1'b0, 16'd8, 16'd3, 2'b00, 16'h0008, 24};
        tbl[1] = '{1'b0, 16'd2, 16'd1, 2'b11, 16'h000A, 2};
        tbl[2] = '{1'b1, 16'd2, 16'd1, 2'b00, 16'h0008, 2};
        tbl[3] = '{1'b1, 16'd1, 16'd0, 2'b01, 16'h0007, 1};
        tbl[4] = '{1'b0, 16'd0, 16'd5, 2'b01, 16'h0007, 0};
        tbl[5] = '{1'b1, 16'd3, 16'd2, 2'b00, 16'h0004, 6};
        tbl[6] = '{1'b1, 16'd5, 16'd1, 2'b01, 16'hFFFF, 5};
        tbl[7] = '{1'b0, 16'd1, 16'd1, 2'b00, 16'h0000, 1};
        tbl[8] = '{1'b1, 16'd1, 16'd1, 2'b01, 16'hFFFF, 1};
        tbl[9] = '{1'b0, 16'd1, 16'd1, 2'b00, 16'h0000, 1};

        #12;
        chk("reset_ab_busy_done_ready", 32'({a, b, busy, done, bus.cmd_ready}), 32'(5'b00001));
        chk("reset_position", 32'(position), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hand-computed command table, chained from the reset phase.
        for (int i = 0; i < 10; i++) begin
            run_cmd(tbl[i].dir, tbl[i].steps, tbl[i].period, lat);
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("tbl%0d_ab", i), 32'({a, b}), 32'(tbl[i].ab));
            chk($sformatf("tbl%0d_position", i), 32'(position), 32'(tbl[i].pos));
        end

        // Back-to-back with cmd_valid held: second accept one cycle after done.
        bus.cmd_dir    = 1'b0;
        bus.cmd_steps  = 16'd2;
        bus.cmd_period = 16'd1;
        bus.cmd_valid  = 1'b1;
        cyc_step();
        cyc_step();
        cyc_step();
        chk("b2b_first_done", 32'({busy, done, bus.cmd_ready}), 32'(3'b011));
        cyc_step();
        chk("b2b_second_accept", 32'({busy, bus.cmd_ready}), 32'(2'b10));
        bus.cmd_valid = 1'b0;
        guard = 0;
        while ((m_busy || m_done || busy) && guard < 100) begin
            cyc_step();
            guard++;
        end
        chk("b2b_position", 32'(position), 32'h0004);

        // Abort on the edge where the second transition is due.
        pos0 = m_pos;
        bus.cmd_dir    = 1'b0;
        bus.cmd_steps  = 16'd5;
        bus.cmd_period = 16'd4;
        bus.cmd_valid  = 1'b1;
        cyc_step();
        bus.cmd_valid  = 1'b0;
        repeat (7) cyc_step();
        bus.abort = 1'b1;
        cyc_step();
        bus.abort = 1'b0;
        chk("abort_state", 32'({busy, done, bus.cmd_ready}), 32'(3'b001));
        chk("abort_position", 32'(position), 32'(pos0 + 16'h0001));
        bus.cmd_dir    = 1'b1;
        bus.cmd_steps  = 16'd1;
        bus.cmd_period = 16'd1;
        bus.cmd_valid  = 1'b1;
        cyc_step();
        bus.cmd_valid  = 1'b0;
        chk("abort_next_accept", 32'({busy, done}), 32'(2'b10));
        guard = 0;
        while ((m_busy || m_done || busy) && guard < 100) begin
            cyc_step();
            guard++;
        end
        chk("abort_then_ccw_position", 32'(position), 32'(pos0));

        // Random commands with fields churning and occasional aborts mid-run.
        for (int i = 0; i < 100; i++) begin
            bus.cmd_dir    = 1'($urandom_range(0, 1));
            bus.cmd_steps  = 16'($urandom_range(0, 12));
            bus.cmd_period = 16'($urandom_range(0, 3));
            bus.cmd_valid  = 1'b1;
            cyc_step();
            bus.cmd_valid  = 1'b0;
            guard = 0;
            while ((m_busy || m_done) && guard < 500) begin
                bus.cmd_dir    = 1'($urandom_range(0, 1));
                bus.cmd_steps  = 16'($urandom);
                bus.cmd_period = 16'($urandom);
                bus.abort      = ($urandom_range(0, 39) == 0);
                cyc_step();
                guard++;
            end
            bus.abort = 1'b0;
            repeat ($urandom_range(0, 2)) cyc_step();
        end
        chk("loopback_decoder_vs_position", 32'(position), 32'(dec_pos));
        chk("loopback_model_vs_position", 32'(position), 32'(m_pos));
        chk("loopback_illegal_jumps", 32'(illegal), 32'd0);

        // Asynchronous reset in the middle of a command.
        bus.cmd_dir    = 1'b0;
        bus.cmd_steps  = 16'd10;
        bus.cmd_period = 16'd2;
        bus.cmd_valid  = 1'b1;
        cyc_step();
        bus.cmd_valid  = 1'b0;
        repeat (5) cyc_step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_ab_busy_done_ready", 32'({a, b, busy, done, bus.cmd_ready}), 32'(5'b00001));
        chk("midrun_reset_position", 32'(position), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(1'b0, 16'd1, 16'd1, lat);
        chk("post_reset_first_cw_ab", 32'({a, b}), 32'(2'b10));
        chk("post_reset_position", 32'(position), 32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
